// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity type codes
// and the supported oversampling ratios. Used by both rx and tx stages.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHK    = 3'd5
  } rx_state_e;

  localparam logic PAR_TYP_ODD  = 1'b1;
  localparam logic PAR_TYP_EVEN = 1'b0;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver bundle: serial line and frame configuration in, parallel word
// and status pulses out.
//   master : driver side (transmit stage / testbench)
//   slave  : uart_rx
interface uart_rx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_ERR;
  logic                      STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period timing and majority-vote sampling for the UART receiver.
//   clk, rst_n   : clock, async active-low reset
//   rx_s         : synchronized serial line
//   cnt_en       : run edge_cnt (low -> held at 0)
//   prescale     : clocks per bit (held for the frame)
//   sampled_bit  : majority of the three mid-bit samples
//   bit_done     : edge_cnt == prescale-1 (last cycle of the bit)
//   sample_done  : one-cycle pulse, sampled_bit freshly updated
module uart_rx_sampler #(
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_s,
  input  logic          cnt_en,
  input  logic [PW-1:0] prescale,
  output logic          sampled_bit,
  output logic          bit_done,
  output logic          sample_done
);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] TWO = PW'(2);

  logic [PW-1:0] edge_cnt, half;
  logic [2:0]    smp;

  assign half     = prescale >> 1;
  assign bit_done = cnt_en && (edge_cnt == prescale - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt    <= '0;
      smp         <= 3'b111;
      sampled_bit <= 1'b1;
      sample_done <= 1'b0;
    end else begin
      if (!cnt_en || bit_done) edge_cnt <= '0;
      else                     edge_cnt <= edge_cnt + ONE;

      if (cnt_en && edge_cnt == half - ONE) smp[0] <= rx_s;
      if (cnt_en && edge_cnt == half)       smp[1] <= rx_s;
      if (cnt_en && edge_cnt == half + ONE) smp[2] <= rx_s;

      // vote one cycle after the last sample so all three are settled
      sample_done <= 1'b0;
      if (cnt_en && edge_cnt == half + TWO) begin
        sampled_bit <= (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        sample_done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, optional parity,
// 1 stop. Oversampled at PRESCALE clocks/bit with a 3-sample majority vote.
//   CLK, RST_n : clock, async active-low reset
//   bus.slave  : RX_IN/PRESCALE/PAR_EN/PAR_TYP in;
//                P_DATA, DATA_VALID/PAR_ERR/STP_ERR one-cycle pulses out
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic     CLK,
  input  logic     RST_n,
  uart_rx_if.slave bus
);
  localparam int              BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);

  logic                      rx_meta, rx_s;
  rx_state_e                 state, next_state;
  logic [PRESCALE_WIDTH-1:0] p_q;
  logic                      par_en_q, par_typ_q;
  logic [BW-1:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]     shreg, p_data;
  logic                      par_bad, stop_bit;
  logic                      data_valid, par_err, stp_err;
  logic                      frame_start, cnt_en;
  logic                      sampled_bit, bit_done, sample_done;

  // line is idle-high, so the synchronizer resets to 1
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // The detection cycle is already edge_cnt=0 of the start bit; taking it
  // from CHK as well keeps back-to-back frames on the line's bit grid.
  assign frame_start = (state == IDLE || state == CHK) && !rx_s;
  assign cnt_en      = frame_start || (state inside {START, DATA, PARITY, STOP});

  uart_rx_sampler #(.PW(PRESCALE_WIDTH)) u_sampler (
    .clk         (CLK),
    .rst_n       (RST_n),
    .rx_s        (rx_s),
    .cnt_en      (cnt_en),
    .prescale    (p_q),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done),
    .sample_done (sample_done)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (bit_done) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_done && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done) next_state = CHK;
      CHK:     next_state = rx_s ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      p_q        <= PRESCALE_WIDTH'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_TYP_EVEN;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bit   <= 1'b1;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      if (frame_start) begin
        p_q       <= bus.PRESCALE;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        bit_cnt   <= '0;
        par_bad   <= 1'b0;
      end
      if (state == DATA && sample_done) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
      if (state == DATA && bit_done)    bit_cnt <= bit_cnt + 1'b1;
      if (state == PARITY && sample_done)
        par_bad <= sampled_bit != (par_typ_q ? ~^shreg : ^shreg);
      if (state == STOP && sample_done) stop_bit <= sampled_bit;

      data_valid <= (state == CHK) && stop_bit && !par_bad;
      par_err    <= (state == CHK) && par_bad;
      stp_err    <= (state == CHK) && !stop_bit;
      if (state == CHK && stop_bit && !par_bad) p_data <= shreg;
    end
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that consumes the UART line driven by the transmit stage and reconstructs 8-bit parallel words.
- Frame: 1 start bit (0), 8 data bits LSB-first, optional parity bit, 1 stop bit (1).
- Oversamples at PRESCALE clocks per bit and takes a majority vote of 3 mid-bit samples.
- Reports the word with a one-cycle valid pulse, or flags a parity or stop (framing) error.
- Feeds the system controller/register-file path.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of PRESCALE input and edge counter

Ports:
CLK  input  1  system clock
RST_n  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high, asynchronous to CLK
PRESCALE  input  6  clocks per bit; legal 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  1 = odd parity, 0 = even parity
P_DATA  output  8  last good received word
DATA_VALID  output  1  one-cycle pulse, P_DATA updated
PAR_ERR  output  1  one-cycle pulse, parity mismatch
STP_ERR  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
Interface:
- One clock, CLK. Reset RST_n is asynchronous, active-low.
- Reset values: P_DATA=0x00, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, FSM=IDLE, counters=0, synchronizer flops=1.

Synchronizer and sampling:
- RX_IN passes through a 2-flop synchronizer (rx_s). All logic uses rx_s.
- PRESCALE, PAR_EN and PAR_TYP are captured on the IDLE->START transition and held for the frame.
- PRESCALE values other than 8/16/32 are unsupported.
- edge_cnt counts 0..P-1 within each bit. bit_cnt counts bits within the frame.
- Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the 3, registered at edge_cnt = P/2+2.

FSM states:
- IDLE: rx_s==0 -> START, with edge_cnt=0 on that cycle.
- START: at edge_cnt==P-1: if the voted bit is 0 -> DATA; if 1 (glitch) -> IDLE, no outputs asserted.
- DATA: the voted bit shifts into an 8-bit shift register, LSB first. After the 8th bit ends (edge_cnt==P-1): PAR_EN ? PARITY : STOP.
- PARITY: capture the voted bit. Expected parity = PAR_TYP ? ~^data : ^data. Store a mismatch flag. At edge_cnt==P-1 -> STOP.
- STOP: at edge_cnt==P-1 -> CHK.
- CHK (1 cycle), outputs registered and visible the following cycle:
  - stop==1 and no parity mismatch: P_DATA<=shift reg, DATA_VALID=1.
  - parity mismatch: PAR_ERR=1.
  - stop==0: STP_ERR=1.
  - PAR_ERR and STP_ERR may pulse together. P_DATA is unchanged on any error.
  - Next state: rx_s==0 ? START (edge_cnt=0, back-to-back frame) : IDLE.

Timing and boundaries:
- Latency: DATA_VALID rises 2 (sync) + F*P + 1 cycles after the RX_IN falling edge, where F = 10 + PAR_EN.
- A line stuck low after an error: CHK -> START again. The start check passes and a frame of all zeros is received, yielding STP_ERR every frame until the line returns high. This is required behaviour, not a hang.
- Reset mid-frame: immediate return to IDLE, partial data discarded, no pulses.
- Output pulses are never wider than one CLK.
- P_DATA is stable whenever DATA_VALID=0.

Decomposition:
- Package uart_pkg holds:
  - state encodings IDLE/START/DATA/PARITY/STOP/CHK (3-bit);
  - constants for PAR_TYP_ODD=1 and PAR_TYP_EVEN=0;
  - constants for legal prescale values 8/16/32.
- The transmit stage should reuse the package.
- One sub-module: uart_rx_sampler. It holds edge_cnt, the 3-sample capture and the majority vote, and outputs sampled_bit, bit_done (edge_cnt==P-1) and sample_done.
- The FSM, shift register and checks stay in uart_rx.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=1, send 0xA5 with odd parity bit 1 -> P_DATA=0xA5, one DATA_VALID pulse at cycle 2+88+1, no errors.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity forced to 1 (correct is 0) -> PAR_ERR one pulse, DATA_VALID=0, P_DATA keeps its prior value.
- PRESCALE=32, PAR_EN=0, send 0x81 with stop bit 0 -> STP_ERR one pulse, no DATA_VALID. After the line returns high, send 0x7E -> P_DATA=0x7E.
- PRESCALE=8: drive RX_IN low for 3 clocks, then high -> start rejected, FSM back to IDLE, no pulses.
- PRESCALE=8, PAR_EN=0, back-to-back 0x00 then 0xFF with no idle gap -> two DATA_VALID pulses exactly 80 cycles apart, with P_DATA=0x00 then 0xFF.
- Assert RST_n low during data bit 4 of 0x55, release, then send 0xC3 -> no pulse for the aborted frame, P_DATA=0xC3 after the second frame.
